// File: rtl/calculator_pkg.sv
// Shared types and widths for the calculator datapath.
package calculator_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } addsub_state_e;

endpackage

// File: rtl/adder_slice_c.sv
// W-bit ripple-carry adder built from chained full adders, with carry-in and carry-out exposed.
module adder_slice_c #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (carry[i]),
            .sum_o (sum_o[i]),
            .cout_o(carry[i+1])
        );
    end

    assign cout_o = carry[W];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of the ripple-carry chains.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/addsub_multicycle.sv
// Sequential WIDTH-bit add/subtract that reuses one SLICE_W-bit adder over WIDTH/SLICE_W cycles,
// LSB slice first, with valid/ready handshakes on input and output.
module addsub_multicycle
    import calculator_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SLICE_W = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("addsub_multicycle: WIDTH must be a multiple of SLICE_W");
    end

    addsub_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic               last;

    assign in_ready_o = (state_q == IDLE) && !rst_i;
    assign last       = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_slice_c #(
        .W(SLICE_W)
    ) u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .cin_i (carry_q),
        .sum_o (slice_s),
        .cout_o(slice_c)
    );

    // Accumulator with the current slice merged in; becomes the full result on the last slice.
    always_comb begin
        acc_d = acc_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                acc_d[i*SLICE_W +: SLICE_W] = slice_s;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            cout_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        a_q     <= a_i;
                        // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                        b_q     <= (op_i == OP_SUB) ? ~b_i : b_i;
                        carry_q <= op_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_c;
                    if (last) begin
                        sum_o       <= acc_d;
                        cout_o      <= slice_c;
                        ovf_o       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                        out_valid_o <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench driving three configurations (64/32, 32/32, 64/16) with shared operands.
module tb_addsub_multicycle;
    import calculator_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        op;

    logic        r64, r32, r16;
    logic        v64, v32, v16;
    logic        or64, or32, or16;
    logic [63:0] s64, s16;
    logic [31:0] s32;
    logic        c64, c32, c16;
    logic        o64, o32, o16;

    addsub_multicycle #(.WIDTH(64), .SLICE_W(32)) u_d64 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r64),
        .a_i(a), .b_i(b), .op_i(op), .out_valid_o(v64), .out_ready_i(or64),
        .sum_o(s64), .cout_o(c64), .ovf_o(o64)
    );

    addsub_multicycle #(.WIDTH(32), .SLICE_W(32)) u_d32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r32),
        .a_i(a[31:0]), .b_i(b[31:0]), .op_i(op), .out_valid_o(v32), .out_ready_i(or32),
        .sum_o(s32), .cout_o(c32), .ovf_o(o32)
    );

    addsub_multicycle #(.WIDTH(64), .SLICE_W(16)) u_d16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(r16),
        .a_i(a), .b_i(b), .op_i(op), .out_valid_o(v16), .out_ready_i(or16),
        .sum_o(s16), .cout_o(c16), .ovf_o(o16)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    exp_t q16[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit hold        = 1'b0;
    bit stall       = 1'b0;
    bit pv64 = 1'b0, pv32 = 1'b0, pv16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on w-bit unsigned and signed interpretations.
    function automatic exp_t model(logic [63:0] ia, logic [63:0] ib, logic sub, int w, int acc);
        exp_t e;
        logic signed [67:0] m, half, ua, ub, sa, sb, r, sr;
        m    = 68'sd1 <<< w;
        half = m >>> 1;
        ua   = {4'b0, ia} & (m - 68'sd1);
        ub   = {4'b0, ib} & (m - 68'sd1);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        r    = sub ? ua - ub : ua + ub;
        sr   = sub ? sa - sb : sa + sb;
        e.cout = sub ? (ua >= ub) : (r >= m);
        if (r < 0) r = r + m;
        if (r >= m) r = r - m;
        e.sum = r[63:0];
        e.ovf = (sr < -half) || (sr >= half);
        e.acc = acc;
        return e;
    endfunction

    task automatic cmp(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic flag_fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event, required none", name);
    endtask

    task automatic check_out(string tag, exp_t e, logic [63:0] s, logic c, logic o, int n);
        cmp({tag, " sum"}, s, e.sum);
        cmp({tag, " cout"}, 64'(c), 64'(e.cout));
        cmp({tag, " ovf"}, 64'(o), 64'(e.ovf));
        cmp({tag, " latency"}, 64'(cyc - e.acc), 64'(n));
    endtask

    // Monitor: compare on each rising out_valid; also drives the consumer ready lines.
    always @(negedge clk) begin
        if (!rst) begin
            if (v64 && !pv64) begin
                if (q64.size() == 0) flag_fail("d64 unexpected out_valid");
                else check_out("d64", q64.pop_front(), s64, c64, o64, 2);
            end
            if (v32 && !pv32) begin
                if (q32.size() == 0) flag_fail("d32 unexpected out_valid");
                else check_out("d32", q32.pop_front(), {32'b0, s32}, c32, o32, 1);
            end
            if (v16 && !pv16) begin
                if (q16.size() == 0) flag_fail("d16 unexpected out_valid");
                else check_out("d16", q16.pop_front(), s16, c16, o16, 4);
            end
        end
        pv64 = v64;
        pv32 = v32;
        pv16 = v16;
        or64 = hold ? 1'b0 : (stall ? ($urandom_range(2) != 0) : 1'b1);
        or32 = hold ? 1'b0 : (stall ? ($urandom_range(2) != 0) : 1'b1);
        or16 = hold ? 1'b0 : (stall ? ($urandom_range(2) != 0) : 1'b1);
    end

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic issue(logic [63:0] ia, logic [63:0] ib, logic iop);
        int waited = 0;
        while (!(r64 && r32 && r16) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!(r64 && r32 && r16)) begin
            flag_fail("issue in_ready timeout");
            return;
        end
        a        = ia;
        b        = ib;
        op       = iop;
        in_valid = 1'b1;
        q64.push_back(model(ia, ib, iop, 64, cyc + 1));
        q32.push_back(model(ia, ib, iop, 32, cyc + 1));
        q16.push_back(model(ia, ib, iop, 64, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((q64.size() + q32.size() + q16.size() != 0 || v64 || v32 || v16) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) flag_fail("drain timeout");
        @(negedge clk);
    endtask

    logic [63:0] hs;
    logic        hc, ho;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = OP_ADD;
        repeat (2) @(negedge clk);
        cmp("reset out_valid", 64'(v64), 64'd0);
        cmp("reset in_ready", 64'(r64), 64'd0);
        cmp("reset sum", s64, 64'd0);
        cmp("reset cout", 64'(c64), 64'd0);
        cmp("reset ovf", 64'(o64), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        cmp("in_ready after reset", 64'(r64 & r32 & r16), 64'd1);

        issue(64'h0000_0000_FFFF_FFFF, 64'd1, OP_ADD);
        issue(64'd0, 64'd1, OP_SUB);
        issue(64'd5, 64'd3, OP_SUB);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
        issue(64'h8000_0000_0000_0000, 64'd1, OP_SUB);
        drain();

        // Backpressure: all consumers stalled while inputs churn.
        hold = 1'b1;
        issue(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, OP_SUB);
        for (int i = 0; i < 20 && !(v64 && v32 && v16); i++) @(negedge clk);
        hs = s64;
        hc = c64;
        ho = o64;
        for (int i = 0; i < 5; i++) begin
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            op       = 1'($urandom);
            in_valid = (i % 2 == 0);
            @(negedge clk);
            cmp("stall out_valid", 64'(v64), 64'd1);
            cmp("stall sum", s64, hs);
            cmp("stall cout/ovf", {62'd0, c64, o64}, {62'd0, hc, ho});
            cmp("stall in_ready", 64'(r64 | r32 | r16), 64'd0);
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        issue(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, OP_ADD);
        drain();

        // Asynchronous reset while every unit is in RUN.
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, OP_ADD);
        drain();
        issue(64'h5555_5555_5555_5555, 64'h2222_2222_2222_2222, OP_ADD);
        #1 rst = 1'b1;
        #1;
        cmp("async rst out_valid", 64'(v64 | v32 | v16), 64'd0);
        cmp("async rst sum", s64, 64'd0);
        cmp("async rst in_ready", 64'(r64), 64'd0);
        q64.delete();
        q32.delete();
        q16.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        cmp("no out_valid after reset", 64'(v64 | v32 | v16), 64'd0);
        issue(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0100, OP_SUB);
        drain();

        // Random ops with random consumer stalls.
        stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(7) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(7) == 0) rb = 64'h8000_0000_0000_0000;
            issue(ra, rb, 1'($urandom));
        end
        drain();
        stall = 1'b0;
        cmp("queues empty", 64'(q64.size() + q32.size() + q16.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_multicycle.md
# addsub_multicycle

Parametrised sequential add/subtract unit for the calculator datapath. It computes a WIDTH-bit sum or difference by iterating a SLICE_W-bit carry-chained adder over WIDTH/SLICE_W cycles, LSB slice first. This lets the 64-bit calculator reuse the 32-bit adder datapath instead of building a full-width ripple chain. It adds carry-out, signed overflow, subtract mode and a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 64, total operand/result width
- SLICE_W, DATA_W (calculator_pkg, 32), bits processed per cycle; WIDTH % SLICE_W == 0 required, elaboration error otherwise
- Derived: N = WIDTH/SLICE_W (N ≥ 1); CNT_W = max(1, $clog2(N))

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock, all flops on rising edge
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  operand request valid
- in_ready_o  out  1  unit can accept; = (state==IDLE) && !rst_i
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- op_i  in  1  addsub_op_e: OP_ADD=0, OP_SUB=1
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- sum_o  out  WIDTH  A+B or A−B, modulo 2^WIDTH
- cout_o  out  1  carry out of MSB (for SUB: 1 = no borrow)
- ovf_o  out  1  two's-complement signed overflow

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE, slice counter 0, carry 0, out_valid_o 0, sum_o 0, cout_o 0, ovf_o 0.
- IDLE: on in_valid_i && in_ready_o at an edge:
  - latch a_i into the A register.
  - latch b_i (or ~b_i when op_i=OP_SUB) into the B register.
  - set carry reg = op_i (1 for SUB); clear counter; clear sum reg; go RUN.
- RUN, counter k (0..N−1): each edge computes slice k = A[k] + B[k] + carry and does:
  - write the slice result into sum reg bits [k*SLICE_W +: SLICE_W];
  - carry ← slice carry-out.
  - if k==N−1: cout_o ← slice carry-out; ovf_o ← (A_msb == B_msb) && (result_msb != A_msb), using the latched and possibly inverted B; go DONE. Otherwise k ← k+1.
- DONE: out_valid_o=1. On out_ready_i → IDLE; out_valid_o drops next cycle.
- sum_o, cout_o and ovf_o are registered. They hold the last result until the next result completes, and read 0 after reset.
- Operand inputs and op_i are ignored outside the IDLE acceptance edge. Changing them during RUN/DONE has no effect.
- in_valid_i outside IDLE is not accepted; no queuing.

## Timing
- Acceptance edge E0. Slice k is written at edge E(k+1). out_valid_o rises after E(N), i.e. N cycles after acceptance.
- out_valid_o stays high, with outputs stable, until out_ready_i is sampled high. There is no timeout.
- The earliest next acceptance is the edge after DONE→IDLE. Peak throughput is one op per N+2 cycles.
- N=1: RUN lasts one cycle; latency is 1.
- rst_i asserted in any state:
  - state → IDLE and out_valid_o → 0 immediately (asynchronous); in_ready_o = 0 while rst_i is high.
  - an in-flight op is discarded; no out_valid_o follows after release.
- in_valid_i and out_ready_i are both irrelevant in RUN.

## Structure
- calculator_pkg additions: typedef enum logic {OP_ADD, OP_SUB} addsub_op_e; typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_e.
- One sub-module, adder_slice_c (parameter W): a W-bit ripple chain of full_adder with cin/cout. This is the existing generate-chained pattern with the carry ports exposed.
- Top level contains the FSM, counter, and A/B/sum/carry registers. Slices are selected by indexed part-select.

## Test plan
- Carry across slices (WIDTH=64, SLICE_W=32): ADD 0x0000_0000_FFFF_FFFF + 1 → sum 0x0000_0001_0000_0000, cout 0, ovf 0; out_valid exactly 2 cycles after acceptance.
- Subtract: SUB 0 − 1 → 0xFFFF_FFFF_FFFF_FFFF, cout 0, ovf 0. SUB 5 − 3 → 2, cout 1.
- Overflow and carry:
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, ovf 1, cout 0.
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → 0, cout 1, ovf 0.
  - SUB 0x8000_0000_0000_0000 − 1 → ovf 1.
- Backpressure: hold out_ready_i low 5 cycles while toggling a_i/b_i/in_valid_i. Required: out_valid_o and outputs stay stable, in_ready_o stays 0, no second acceptance; after out_ready_i, the next op is accepted with its fresh operands.
- Reset mid-RUN: assert rst_i one cycle after acceptance. Required: out_valid_o and sum_o are 0 without waiting for a clock edge, no out_valid_o after release, and the following op returns a correct result.
- Parameter sweep: (32,32) N=1 and (64,16) N=4. Run 1000 random ADD/SUB ops against a reference model with random ready stalls. Check sum/cout/ovf and latency = N.
